two_to_four: RTL and testbench

// - 2-to-4 binary decoder with enable: one-hot decode of a 2-bit select onto 4 lines.
// - Combinational output for glue logic; registered copy for timing-critical consumers.
// - Sits between address/select generation and per-target enable lines (e.g. chip selects).
// - Optional per-line saturating hit counters for debug/coverage.
//

---
 rtl/two_to_four.sv | 53 +++++
 tb/tb_two_to_four.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/two_to_four.sv
// 2-to-4 one-hot decoder with enable, plus a registered copy of the decode and enable.
// Define TWO_TO_FOUR_HIT_CNT_EN to add per-line saturating hit counters on port hit_cnt.
module two_to_four #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           a,
    output logic [3:0]           bcode,
    output logic [3:0]           bcode_q,
    output logic                 valid_q
`ifdef TWO_TO_FOUR_HIT_CNT_EN
    ,
    output logic [4*CNT_W-1:0]   hit_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("two_to_four: CNT_W must be at least 1");
    end

    assign bcode = en ? (4'b0001 << a) : 4'b0000;

    // Registered copy for consumers that need a clean flop output; clears asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcode_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            bcode_q <= bcode;
            valid_q <= en;
        end
    end

`ifdef TWO_TO_FOUR_HIT_CNT_EN
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        // bcode[i] is already qualified by en, so it marks a hit on this line.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (bcode[i] && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_two_to_four.sv
// Self-checking bench for two_to_four: vector tables for the decode, a scoreboard queue
// for the registered path, and hand-written reset and hit-counter sequences.
module tb_two_to_four;

    localparam int CNT_W = 2;

    logic                clk;
    logic                rst;
    logic                en;
    logic [1:0]          a;
    logic [3:0]          bcode;
    logic [3:0]          bcode_q;
    logic                valid_q;
`ifdef TWO_TO_FOUR_HIT_CNT_EN
    logic [4*CNT_W-1:0]  hit_cnt;
`endif

    logic clk_run;
    int   compared;
    int   mismatched;

    typedef struct packed {
        logic       en;
        logic [1:0] a;
        logic [3:0] exp;
    } vec_t;

    vec_t       sweep[6];
    logic [4:0] exp_q[$];

    two_to_four #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .bcode   (bcode),
        .bcode_q (bcode_q),
`ifdef TWO_TO_FOUR_HIT_CNT_EN
        .valid_q (valid_q),
        .hit_cnt (hit_cnt)
`else
        .valid_q (valid_q)
`endif
    );

    // Clock stays low until the combinational-only phase is over.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [3:0] decode(input logic e, input logic [1:0] sel);
        logic [3:0] r;
        r = 4'b0000;
        if (e) begin
            case (sel)
                2'd0: r = 4'b0001;
                2'd1: r = 4'b0010;
                2'd2: r = 4'b0100;
                default: r = 4'b1000;
            endcase
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic [1:0] sel);
        en = e;
        a  = sel;
        exp_q.push_back({decode(e, sel), e});
    endtask

    task automatic check_registered(input string name);
        logic [4:0] exp;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", name, {bcode_q, valid_q});
        end else begin
            exp = exp_q.pop_front();
            check_output(name, 16'({bcode_q, valid_q}), 16'(exp));
        end
        check_output({name, "_inv"}, 16'(valid_q ? 4'h0 : bcode_q), 16'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clk        = 1'b0;
        clk_run    = 1'b0;
        rst        = 1'b0;
        en         = 1'b0;
        a          = 2'b00;

        sweep[0] = '{en: 1'b0, a: 2'b00, exp: 4'b0000};
        sweep[1] = '{en: 1'b1, a: 2'b01, exp: 4'b0010};
        sweep[2] = '{en: 1'b1, a: 2'b10, exp: 4'b0100};
        sweep[3] = '{en: 1'b0, a: 2'b11, exp: 4'b0000};
        sweep[4] = '{en: 1'b1, a: 2'b00, exp: 4'b0001};
        sweep[5] = '{en: 1'b0, a: 2'b10, exp: 4'b0000};

        // Combinational sweep with the clock idle and reset never asserted.
        for (int i = 0; i < 6; i++) begin
            en = sweep[i].en;
            a  = sweep[i].a;
            #200;
            check_output($sformatf("sweep%0d", i), 16'(bcode), 16'(sweep[i].exp));
        end

        for (int i = 0; i < 8; i++) begin
            en = i[2];
            a  = i[1:0];
            #10;
            check_output($sformatf("exh_en%0d_a%0d", i[2], i[1:0]), 16'(bcode), 16'(decode(i[2], i[1:0])));
            check_output($sformatf("onehot0_%0d", i), 16'($onehot0(bcode)), 16'd1);
        end

        // Reset pulse with the clock running; registers must clear without an edge.
        en      = 1'b1;
        a       = 2'b01;
        clk_run = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_output("reset_state", 16'({bcode_q, valid_q}), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: outputs change only on the first posedge after the inputs.
        apply_stimulus(1'b1, 2'b11);
        #1;
        check_output("latency_before", 16'({bcode_q, valid_q}), 16'h0);
        @(posedge clk);
        #1;
        check_registered("latency_after");

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            apply_stimulus(1'($urandom_range(1)), 2'($urandom_range(3)));
            @(posedge clk);
            #1;
            check_registered($sformatf("stream%0d", i));
        end

        // Asynchronous reset between edges while bcode_q holds 0100.
        @(negedge clk);
        apply_stimulus(1'b1, 2'b10);
        @(posedge clk);
        #1;
        check_registered("pre_async");
        #2;
        rst = 1'b1;
        #1;
        check_output("async_regs", 16'({bcode_q, valid_q}), 16'h0);
        check_output("async_bcode", 16'(bcode), 16'h4);
        @(posedge clk);
        #1;
        check_output("reset_hold", 16'({bcode_q, valid_q}), 16'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef TWO_TO_FOUR_HIT_CNT_EN
        check_output("cnt_reset", 16'(hit_cnt), 16'h0);
        en = 1'b1;
        a  = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check_output("cnt_two", 16'(hit_cnt), 16'h20);
        end
        check_output("cnt_sat_line2", 16'(hit_cnt[2*CNT_W +: CNT_W]), 16'd3);
        check_output("cnt_other_lines", 16'({hit_cnt[3*CNT_W +: CNT_W], hit_cnt[1*CNT_W +: CNT_W], hit_cnt[0 +: CNT_W]}), 16'h0);
        @(negedge clk);
        en = 1'b0;
        a  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        #1;
        check_output("cnt_hold_en0", 16'(hit_cnt), 16'h30);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
